img_filter_3x3: RTL and testbench

//  Streaming 3x3 neighbourhood filter on the 8-bit grayscale pixel stream from the image loader.

---
 rtl/img_filter_3x3_if.sv | 24 ++
 rtl/img_filter_3x3.sv | 205 ++++++++++++++++++++
 tb/tb_img_filter_3x3.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/img_filter_3x3_if.sv
// Pixel stream bundle between the image loader, the 3x3 filter and the RGB path.
`timescale 1ns/1ps
interface img_filter_3x3_if #(
  parameter int DATA_W = 8
);
  logic              i_vsync;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic [1:0]        i_mode;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_frame_done;
  logic              o_overrun;

  modport master (
    output i_vsync, i_valid, i_data, i_mode,
    input  o_data, o_valid, o_frame_done, o_overrun
  );

  modport slave (
    input  i_vsync, i_valid, i_data, i_mode,
    output o_data, o_valid, o_frame_done, o_overrun
  );
endinterface

// File: rtl/img_filter_3x3.sv
// Streaming 3x3 neighbourhood filter (bypass / blur / Sobel magnitude / sharpen) with
// two line buffers, a window register and two arithmetic pipeline stages.
`timescale 1ns/1ps
module img_filter_3x3 #(
  parameter int IMG_W  = 225,
  parameter int IMG_H  = 225,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  img_filter_3x3_if.slave bus
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int PTR_W = $clog2(IMG_W);
  localparam int SUM_W = DATA_W + 4;

  localparam logic [CNT_W-1:0] FILL_END  = CNT_W'(IMG_W + 1);
  localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] FLUSH_END = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(IMG_W - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  function automatic logic [SUM_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(SUM_W-DATA_W){1'b0}}, v};
  endfunction

  function automatic logic [SUM_W-1:0] mag_abs(input logic signed [SUM_W-1:0] v);
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] sat_u(input logic [SUM_W-1:0] v);
    return (|v[SUM_W-1:DATA_W]) ? '1 : v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] clamp_s(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])            return '0;
    if (|v[SUM_W-2:DATA_W])    return '1;
    return v[DATA_W-1:0];
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  in_cnt;
  logic [COL_W-1:0]  flush_cnt;
  logic [COL_W-1:0]  out_col;
  logic [ROW_W-1:0]  out_row;
  logic [PTR_W-1:0]  ptr;
  logic [1:0]        mode_q;
  logic              overrun;

  logic              accept, tick, emit;
  logic [DATA_W-1:0] shift_in, lb0_rd, lb1_rd;

  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];

  logic [DATA_W-1:0] win_p0 [3][3];
  logic              vld_p0, border_p0, last_p0;

  logic [SUM_W-1:0]        blur_p1;
  logic signed [SUM_W-1:0] gx_p1, gy_p1, sharp_p1;
  logic [DATA_W-1:0]       centre_p1;
  logic                    vld_p1, border_p1, last_p1;
  logic [DATA_W-1:0]       res_p1;

  logic [DATA_W-1:0] data_p2;
  logic              vld_p2, done_p2;

  always_comb begin
    accept   = bus.i_vsync && bus.i_valid && (state == IDLE || state == FILL || state == RUN);
    tick     = accept || (bus.i_vsync && state == FLUSH);
    emit     = tick && (state == RUN || state == FLUSH || (state == FILL && in_cnt == FILL_END));
    shift_in = (state == FLUSH) ? '0 : bus.i_data;
  end

  assign lb0_rd = lb0[ptr];
  assign lb1_rd = lb1[ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      flush_cnt <= '0;
      out_col   <= '0;
      out_row   <= '0;
      ptr       <= '0;
      mode_q    <= '0;
      overrun   <= 1'b0;
      vld_p0    <= 1'b0;
    end else if (!bus.i_vsync) begin
      state     <= IDLE;
      in_cnt    <= '0;
      flush_cnt <= '0;
      out_col   <= '0;
      out_row   <= '0;
      ptr       <= '0;
      mode_q    <= bus.i_mode;
      overrun   <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= emit;
      if (tick)   ptr    <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (emit) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      if ((state == FLUSH || state == DONE) && bus.i_valid) overrun <= 1'b1;
      case (state)
        IDLE:  if (accept) state <= FILL;
        FILL:  if (accept && in_cnt == FILL_END) state <= RUN;
        RUN:   if (accept && in_cnt == LAST_IN) begin
                 state     <= FLUSH;
                 flush_cnt <= '0;
               end
        FLUSH: begin
                 flush_cnt <= flush_cnt + 1'b1;
                 if (flush_cnt == FLUSH_END) state <= DONE;
               end
        DONE:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: line buffers and window; the centre of the window is output index out_row/out_col
  always_ff @(posedge clk) begin
    if (tick) begin
      lb0[ptr] <= shift_in;
      lb1[ptr] <= lb0_rd;
      for (int y = 0; y < 3; y++) begin
        win_p0[y][0] <= win_p0[y][1];
        win_p0[y][1] <= win_p0[y][2];
      end
      win_p0[2][2] <= shift_in;
      win_p0[1][2] <= lb0_rd;
      win_p0[0][2] <= lb1_rd;
    end
    if (emit) begin
      border_p0 <= (out_row == '0) || (out_row == LAST_ROW) || (out_col == '0) || (out_col == LAST_COL);
      last_p0   <= (out_row == LAST_ROW) && (out_col == LAST_COL);
    end
  end

  // Stage p1: kernel sums for every mode
  always_ff @(posedge clk) begin
    blur_p1   <= zext(win_p0[0][0]) + (zext(win_p0[0][1]) << 1) + zext(win_p0[0][2])
               + (zext(win_p0[1][0]) << 1) + (zext(win_p0[1][1]) << 2) + (zext(win_p0[1][2]) << 1)
               + zext(win_p0[2][0]) + (zext(win_p0[2][1]) << 1) + zext(win_p0[2][2]);
    gx_p1     <= $signed(zext(win_p0[0][2]) + (zext(win_p0[1][2]) << 1) + zext(win_p0[2][2]))
               - $signed(zext(win_p0[0][0]) + (zext(win_p0[1][0]) << 1) + zext(win_p0[2][0]));
    gy_p1     <= $signed(zext(win_p0[2][0]) + (zext(win_p0[2][1]) << 1) + zext(win_p0[2][2]))
               - $signed(zext(win_p0[0][0]) + (zext(win_p0[0][1]) << 1) + zext(win_p0[0][2]));
    sharp_p1  <= $signed((zext(win_p0[1][1]) << 2) + zext(win_p0[1][1]))
               - $signed(zext(win_p0[0][1]) + zext(win_p0[1][0]) + zext(win_p0[1][2]) + zext(win_p0[2][1]));
    centre_p1 <= win_p0[1][1];
    border_p1 <= border_p0;
    last_p1   <= last_p0;
  end

  always_comb begin
    res_p1 = centre_p1;
    if (!border_p1) begin
      case (mode_q)
        2'd1:    res_p1 = blur_p1[DATA_W+3:4];
        2'd2:    res_p1 = sat_u(mag_abs(gx_p1) + mag_abs(gy_p1));
        2'd3:    res_p1 = clamp_s(sharp_p1);
        default: res_p1 = centre_p1;
      endcase
    end
  end

  // Stage p2: mode select, saturation and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      done_p2 <= 1'b0;
      data_p2 <= '0;
    end else if (!bus.i_vsync) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      done_p2 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      done_p2 <= vld_p1 && last_p1;
      if (vld_p1) data_p2 <= res_p1;
    end
  end

  assign bus.o_data       = data_p2;
  assign bus.o_valid      = vld_p2;
  assign bus.o_frame_done = done_p2;
  assign bus.o_overrun    = overrun;
endmodule

// File: tb/tb_img_filter_3x3.sv
// Scoreboard bench for img_filter_3x3: a 4x4 instance for directed and random frames,
// and a full-size 225x225 instance for one edge-mode frame.
`timescale 1ns/1ps
module tb_img_filter_3x3;
  localparam int W = 4, H = 4, NP = W * H;
  localparam int BW = 225, BH = 225, BNP = BW * BH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   accept_cyc = 0;
  int   first_out_cyc = 0;
  bit   seen_first = 1'b0;
  int   exp_q[$];
  int   exp_big[$];
  int   big_outs = 0, big_done = 0, big_bad = 0;
  int   mon_e, big_e;

  img_filter_3x3_if #(.DATA_W(8)) sif ();
  img_filter_3x3_if #(.DATA_W(8)) bif ();

  img_filter_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));
  img_filter_3x3 #(.IMG_W(BW), .IMG_H(BH), .DATA_W(8)) dut_big (.clk(clk), .rst_n(rst_n), .bus(bif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: filtered pixel (r,c) of an image, straight from the kernel definitions.
  function automatic int ref_pix(input int img[], input int w, input int h, input int mode,
                                 input int r, input int c);
    int k_blur[3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    int k_gx[3][3]   = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int k_gy[3][3]   = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    int k_sh[3][3]   = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
    int b = 0, gx = 0, gy = 0, s = 0, v;
    if (mode == 0 || r == 0 || r == h - 1 || c == 0 || c == w - 1) return img[r * w + c];
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) begin
        v = img[(r + y - 1) * w + (c + x - 1)];
        b  += k_blur[y][x] * v;
        gx += k_gx[y][x] * v;
        gy += k_gy[y][x] * v;
        s  += k_sh[y][x] * v;
      end
    case (mode)
      1: return b / 16;
      2: begin
           v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
           return (v > 255) ? 255 : v;
         end
      default: return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    endcase
  endfunction

  // Small-instance monitor: every output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sif.o_valid === 1'b1) begin
      if (!seen_first) begin
        seen_first = 1'b1;
        first_out_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got data %0d, required no output", sif.o_data);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("pixel_%0d", mon_e >> 9), int'(sif.o_data), mon_e & 255);
        check($sformatf("frame_done_%0d", mon_e >> 9), int'(sif.o_frame_done), (mon_e >> 8) & 1);
      end
    end else if (sif.o_frame_done === 1'b1) begin
      check("frame_done_without_valid", 1, 0);
    end
  end

  always @(negedge clk) begin
    if (bif.o_valid === 1'b1) begin
      big_outs++;
      if (bif.o_frame_done === 1'b1) big_done++;
      if (exp_big.size() == 0) big_bad++;
      else begin
        big_e = exp_big.pop_front();
        if (int'(bif.o_data) != (big_e & 255) || int'(bif.o_frame_done) != (big_e >> 8)) big_bad++;
      end
    end
  end

  task automatic drive_frame(input int img[], input int mode, input int gap_pct,
                             input int abort_after, input bit hold, input int n_exp);
    int n;
    for (int k = 0; k < n_exp; k++)
      exp_q.push_back((k << 9) | (int'(k == NP - 1) << 8) | ref_pix(img, W, H, mode, k / W, k % W));
    sif.i_valid = 1'b0;
    sif.i_vsync = 1'b0;
    sif.i_mode  = 2'(mode);
    repeat (2) @(negedge clk);
    sif.i_vsync = 1'b1;
    sif.i_mode  = 2'(mode + 1);
    seen_first  = 1'b0;
    n = 0;
    while (n < NP) begin
      if ($urandom_range(99) < gap_pct) sif.i_valid = 1'b0;
      else begin
        sif.i_valid = 1'b1;
        sif.i_data  = 8'(img[n]);
        if (n == W + 1) accept_cyc = cyc + 1;
        n++;
      end
      @(negedge clk);
      if (abort_after >= 0 && n > abort_after) break;
    end
    if (abort_after >= 0) begin
      sif.i_valid = 1'b0;
      sif.i_vsync = 1'b0;
      repeat (6) @(negedge clk);
    end else begin
      sif.i_valid = hold;
      sif.i_data  = 8'($urandom_range(255));
      repeat (W + 8) @(negedge clk);
      sif.i_valid = 1'b0;
    end
  endtask

  initial begin
    int img[];
    int bimg[];
    img = new[NP];
    sif.i_vsync = 1'b0; sif.i_valid = 1'b0; sif.i_data = '0; sif.i_mode = '0;
    bif.i_vsync = 1'b0; bif.i_valid = 1'b0; bif.i_data = '0; bif.i_mode = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_o_valid", int'(sif.o_valid), 0);
    check("reset_o_data", int'(sif.o_data), 0);
    check("reset_o_frame_done", int'(sif.o_frame_done), 0);
    check("reset_o_overrun", int'(sif.o_overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass ramp, continuous input
    foreach (img[i]) img[i] = i;
    drive_frame(img, 0, 0, -1, 1'b0, NP);
    check("bypass_first_out_seen", int'(seen_first), 1);
    check("bypass_latency", first_out_cyc - accept_cyc, 2);
    check("bypass_drain", exp_q.size(), 0);
    check("bypass_no_overrun", int'(sif.o_overrun), 0);

    // Blur of a flat field with input gaps
    foreach (img[i]) img[i] = 100;
    drive_frame(img, 1, 40, -1, 1'b0, NP);
    check("blur_drain", exp_q.size(), 0);

    // Edge on a vertical step
    foreach (img[i]) img[i] = ((i % W) >= 2) ? 200 : 0;
    drive_frame(img, 2, 20, -1, 1'b0, NP);
    check("edge_drain", exp_q.size(), 0);

    // Sharpen of a single bright pixel
    foreach (img[i]) img[i] = (i == W + 1) ? 255 : 0;
    drive_frame(img, 3, 0, -1, 1'b0, NP);
    check("sharpen_drain", exp_q.size(), 0);

    // Abort after pixel 7: only output 0 (tick of pixel 5) reaches o_valid before vsync falls
    foreach (img[i]) img[i] = $urandom_range(255);
    drive_frame(img, 1, 0, 7, 1'b0, 1);
    check("abort_drain", exp_q.size(), 0);
    check("abort_quiet", int'(sif.o_valid), 0);
    foreach (img[i]) img[i] = $urandom_range(255);
    drive_frame(img, 3, 10, -1, 1'b0, NP);
    check("after_abort_drain", exp_q.size(), 0);

    // Overrun: i_valid held through flush
    foreach (img[i]) img[i] = $urandom_range(255);
    drive_frame(img, 2, 0, -1, 1'b1, NP);
    check("overrun_set", int'(sif.o_overrun), 1);
    check("overrun_drain", exp_q.size(), 0);
    sif.i_vsync = 1'b0;
    repeat (2) @(negedge clk);
    check("overrun_cleared", int'(sif.o_overrun), 0);

    for (int f = 0; f < 6; f++) begin
      foreach (img[i]) img[i] = $urandom_range(255);
      drive_frame(img, int'($urandom_range(3)), int'($urandom_range(50)), -1, 1'b0, NP);
      check($sformatf("random_frame_%0d_drain", f), exp_q.size(), 0);
    end

    // Full-size frame, edge mode
    bimg = new[BNP];
    foreach (bimg[i]) bimg[i] = $urandom_range(255);
    for (int k = 0; k < BNP; k++)
      exp_big.push_back((int'(k == BNP - 1) << 8) | ref_pix(bimg, BW, BH, 2, k / BW, k % BW));
    bif.i_mode = 2'd2;
    repeat (2) @(negedge clk);
    bif.i_vsync = 1'b1;
    bif.i_mode  = 2'd0;
    for (int i = 0; i < BNP; i++) begin
      bif.i_valid = 1'b1;
      bif.i_data  = 8'(bimg[i]);
      @(negedge clk);
    end
    bif.i_valid = 1'b0;
    repeat (BW + 10) @(negedge clk);
    check("big_output_count", big_outs, BNP);
    check("big_frame_done_count", big_done, 1);
    check("big_data_errors", big_bad, 0);
    check("big_drain", exp_big.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
